elevador_scheduler: RTL and testbench
=====================================

Name: elevador_scheduler

Overview:
- Central controller for the 5-floor elevator.
- Latches floor-call buttons, runs a collective (SCAN) policy, steps the cabin one floor per TRAVEL_CYCLES, and sequences the door block through an open/done handshake.
- Sits between the user buttons and the door/LED logic. It is the only block that decides cabin position, direction and when the doors operate.

Parameters:
- NUM_FLOORS, 5, number of floors; fixed at 5 for this design.
- TRAVEL_CYCLES, 50_000_000, clock cycles to move one floor (≥2). The bench uses 4.

Ports:
- clk  input  1  system clock.
- rst_a_p  input  1  asynchronous, active-low reset.
- req_n  input  5  floor-call buttons, active-low, asynchronous to clk; bit i = floor i.
- door_done  input  1  pulse from door block: open/close cycle finished, doors closed.
- floor  output  3  current floor, binary 0..4.
- floor_oh  output  5  current floor, one-hot.
- pending  output  5  latched outstanding requests (for call LEDs).
- moving  output  1  cabin travelling between floors.
- dir_up  output  1  1 = up, 0 = down; holds the last travel direction.
- door_open  output  1  request to door block to run an open/close cycle.

Behaviour:
- Reset (rst_a_p=0, async): all outputs and state are forced immediately to their reset values.
  - floor=0, floor_oh=5'b00001, pending=0, moving=0, dir_up=1, door_open=0.
  - Counter=0, state=IDLE, synchronizers=5'b11111.
- Reset mid-MOVE or mid-DOOR: the operation is abandoned and the cabin restarts at floor 0 with no pending requests.
- Request capture:
  - Each req_n bit goes through a 2-FF synchronizer, then a falling-edge detector.
  - pending[i] is set on the 3rd rising clk edge after req_n[i] falls.
  - Holding the button causes no further effect. Glitches shorter than a cycle may be lost (acceptable).
- State machine IDLE / MOVE / DOOR:
  - IDLE, evaluated every cycle, priorities in order:
    - (a) pending[floor]: clear it, door_open←1, go to DOOR.
    - (b) Requests above the current floor and (dir_up=1 or none below): dir_up←1, moving←1, counter←0, go to MOVE.
    - (c) Requests below: dir_up←0, moving←1, counter←0, go to MOVE.
    - (d) Otherwise stay in IDLE.
  - MOVE: counter increments each cycle. When counter == TRAVEL_CYCLES-1:
    - floor←floor±1 per dir_up and floor_oh updates on the same edge; counter←0.
    - If pending[new floor]: clear it, moving←0, door_open←1, go to DOOR.
    - Otherwise stay in MOVE.
  - DOOR: door_open is held high until door_done is sampled high. Then door_open←0, go to IDLE. The next decision happens one cycle later.
- Direction: reverses only from IDLE, and only when no requests remain ahead in the current direction.
- Simultaneous events:
  - A capture edge for the current floor while in DOOR, or on the same edge as an arrival/IDLE clear: the clear wins and the request is absorbed.
  - A capture edge for another floor is always latched.
  - A request for the floor just left, raised during MOVE, is latched and served after reversal.
- Boundaries:
  - Floor is never driven above 4 or below 0; MOVE is entered only toward a pending floor.
  - door_done while not in DOOR is ignored.
  - Counter width is $clog2(TRAVEL_CYCLES). It wraps to 0 only via explicit reload, never by overflow.

Decomposition:
- Package elevador_pkg:
  - NUM_FLOORS=5, FLOOR_W=3.
  - State enum {IDLE, MOVE, DOOR}.
  - DIR_UP=1'b1, DIR_DOWN=1'b0.
  - Function floor_to_oh.
- One sub-module, boton_sync: 5-bit 2-FF synchronizer plus falling-edge detector, output 5-bit one-cycle capture pulse, reset to idle-high.

Test Plan (TRAVEL_CYCLES=4):
- Reset then idle: hold rst_a_p=0 for 20 cycles, release, no buttons.
  - Required: floor=0, floor_oh=00001, pending=0, moving=0, door_open=0, dir_up=1 for 50 cycles.
- Single call up: req_n[2] low for 10 cycles.
  - pending[2]=1 on the 3rd edge; moving=1 one edge later.
  - floor=1 four cycles after moving rises; floor=2, door_open=1, moving=0, pending[2]=0 eight cycles after.
  - door_done pulse → door_open=0 on the next edge.
- Call at current floor: at floor 0 in IDLE, press req_n[0].
  - door_open=1 one edge after pending[0] sets, with no movement.
  - A second press of floor 0 while in DOOR leaves pending[0]=0.
- SCAN ordering: at floor 2 moving up toward 4, press floor 1 then floor 3.
  - Service order is 3, 4, then reversal (dir_up=0) to 1.
  - floor never exceeds 4.
- Door handshake stall: withhold door_done for 100 cycles at floor 2.
  - door_open stays 1 and floor stays 2 throughout.
  - Pending requests for other floors remain latched and are served after door_done.
- Reset mid-MOVE: assert rst_a_p=0 while moving between floors 1 and 2.
  - Outputs take reset values immediately (same timestep, no clock).
  - After release, no motion until a new request arrives.

Source files
------------

// File: rtl/elevador_pkg.sv
// Shared types, widths and helpers for the 5-floor elevator scheduler.
package elevador_pkg;

    localparam int unsigned NUM_FLOORS = 5;
    localparam int unsigned FLOOR_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic [NUM_FLOORS-1:0] floor_to_oh(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] oh;
        oh = '0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (f == FLOOR_W'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/elevador_scheduler_boton_sync.sv
// Per-button 2-FF synchronizer followed by a falling-edge detector.
module boton_sync
    import elevador_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_a_p,
    input  logic [NUM_FLOORS-1:0] req_n,
    output logic [NUM_FLOORS-1:0] fall_c
);

    logic [NUM_FLOORS-1:0] sync1_q, sync1_d;
    logic [NUM_FLOORS-1:0] sync2_q, sync2_d;
    logic [NUM_FLOORS-1:0] prev_q,  prev_d;

    always_comb begin
        sync1_d = req_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Idle level of an unpressed button is high.
    always_ff @(posedge clk or negedge rst_a_p) begin
        if (!rst_a_p) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign fall_c = prev_q & ~sync2_q;

endmodule

// File: rtl/elevador_scheduler.sv
// Elevator controller: latches floor calls, runs SCAN, steps the cabin and
// sequences the door block through an open/done handshake.
module elevador_scheduler
    import elevador_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_a_p,
    input  logic [NUM_FLOORS-1:0] req_n,
    input  logic                  door_done,
    output logic [FLOOR_W-1:0]    floor,
    output logic [NUM_FLOORS-1:0] floor_oh,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open
);

    localparam int unsigned CNT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    state_e                state_q,     state_d;
    logic [FLOOR_W-1:0]    floor_q,     floor_d;
    logic [NUM_FLOORS-1:0] floor_oh_q,  floor_oh_d;
    logic [NUM_FLOORS-1:0] pending_q,   pending_d;
    logic                  moving_q,    moving_d;
    logic                  dir_up_q,    dir_up_d;
    logic                  door_open_q, door_open_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;

    logic [NUM_FLOORS-1:0] capture_c;
    logic [NUM_FLOORS-1:0] above_c, below_c, next_oh_c;
    logic [FLOOR_W-1:0]    next_floor_c;
    logic                  here_c, go_up_c, go_down_c, travel_done_c, arrive_hit_c;

    boton_sync u_boton_sync (
        .clk     (clk),
        .rst_a_p (rst_a_p),
        .req_n   (req_n),
        .fall_c  (capture_c)
    );

    // SCAN view of the request set relative to the cabin.
    always_comb begin
        above_c = '0;
        below_c = '0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (FLOOR_W'(i) > floor_q)      above_c[i] = pending_q[i];
            else if (FLOOR_W'(i) < floor_q) below_c[i] = pending_q[i];
        end
        here_c    = |(pending_q & floor_oh_q);
        go_up_c   = (|above_c) && (dir_up_q || !(|below_c));
        go_down_c = !go_up_c && (|below_c);

        // Saturating step keeps the cabin inside the shaft.
        if (dir_up_q == DIR_UP)
            next_floor_c = (floor_q == TOP_FLOOR) ? floor_q : floor_q + FLOOR_W'(1);
        else
            next_floor_c = (floor_q == '0) ? floor_q : floor_q - FLOOR_W'(1);
        next_oh_c     = floor_to_oh(next_floor_c);
        arrive_hit_c  = |(pending_q & next_oh_c);
        travel_done_c = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_a_p) begin
        if (!rst_a_p) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (here_c)                   state_d = DOOR;
                else if (go_up_c || go_down_c) state_d = MOVE;
            end
            MOVE:    if (travel_done_c && arrive_hit_c) state_d = DOOR;
            DOOR:    if (door_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates; a clear of the served floor overrides a same-edge capture.
    always_comb begin
        floor_d     = floor_q;
        floor_oh_d  = floor_oh_q;
        pending_d   = pending_q | capture_c;
        moving_d    = moving_q;
        dir_up_d    = dir_up_q;
        door_open_d = door_open_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (here_c) begin
                    pending_d   = pending_d & ~floor_oh_q;
                    door_open_d = 1'b1;
                end else if (go_up_c) begin
                    dir_up_d = DIR_UP;
                    moving_d = 1'b1;
                    cnt_d    = '0;
                end else if (go_down_c) begin
                    dir_up_d = DIR_DOWN;
                    moving_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            MOVE: begin
                if (travel_done_c) begin
                    floor_d    = next_floor_c;
                    floor_oh_d = next_oh_c;
                    cnt_d      = '0;
                    if (arrive_hit_c) begin
                        pending_d   = pending_d & ~next_oh_c;
                        moving_d    = 1'b0;
                        door_open_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOOR: begin
                pending_d = pending_d & ~floor_oh_q;
                if (door_done) door_open_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_a_p) begin
        if (!rst_a_p) begin
            floor_q     <= '0;
            floor_oh_q  <= NUM_FLOORS'(1);
            pending_q   <= '0;
            moving_q    <= 1'b0;
            dir_up_q    <= DIR_UP;
            door_open_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            floor_q     <= floor_d;
            floor_oh_q  <= floor_oh_d;
            pending_q   <= pending_d;
            moving_q    <= moving_d;
            dir_up_q    <= dir_up_d;
            door_open_q <= door_open_d;
            cnt_q       <= cnt_d;
        end
    end

    assign floor     = floor_q;
    assign floor_oh  = floor_oh_q;
    assign pending   = pending_q;
    assign moving    = moving_q;
    assign dir_up    = dir_up_q;
    assign door_open = door_open_q;

endmodule

// File: tb/tb_elevador_scheduler.sv
// Directed bench for elevador_scheduler with TRAVEL_CYCLES = 4.
module tb_elevador_scheduler;

    localparam int unsigned TC = 4;

    logic       clk = 1'b0;
    logic       rst_a_p;
    logic [4:0] req_n;
    logic       door_done;
    logic [2:0] floor;
    logic [4:0] floor_oh;
    logic [4:0] pending;
    logic       moving;
    logic       dir_up;
    logic       door_open;

    int n_cmp = 0;
    int n_bad = 0;
    int max_fl = 0;

    typedef struct {
        logic [4:0] req_n;
        logic       dd;
        logic [2:0] fl;
        logic [4:0] pend;
        logic       mov;
        logic       door;
    } vec_t;

    vec_t tbl[$];

    elevador_scheduler #(.TRAVEL_CYCLES(TC)) dut (
        .clk       (clk),
        .rst_a_p   (rst_a_p),
        .req_n     (req_n),
        .door_done (door_done),
        .floor     (floor),
        .floor_oh  (floor_oh),
        .pending   (pending),
        .moving    (moving),
        .dir_up    (dir_up),
        .door_open (door_open)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] fl, input logic [4:0] pend,
                           input logic mov, input logic dir, input logic door);
        logic [4:0] oh;
        oh = 5'b00001 << fl;
        chk({tag, ".floor"},     32'(floor),     32'(fl));
        chk({tag, ".floor_oh"},  32'(floor_oh),  32'(oh));
        chk({tag, ".pending"},   32'(pending),   32'(pend));
        chk({tag, ".moving"},    32'(moving),    32'(mov));
        chk({tag, ".dir_up"},    32'(dir_up),    32'(dir));
        chk({tag, ".door_open"}, 32'(door_open), 32'(door));
    endtask

    task automatic wait_door(input string name, input logic [2:0] fl, input logic dir);
        for (int k = 0; k < 200 && door_open !== 1'b1; k++) begin
            tick;
            if (int'(floor) > max_fl) max_fl = int'(floor);
        end
        chk({name, ".door_open"}, 32'(door_open), 32'd1);
        chk({name, ".floor"},     32'(floor),     32'(fl));
        chk({name, ".dir_up"},    32'(dir_up),    32'(dir));
        chk({name, ".moving"},    32'(moving),    32'd0);
    endtask

    task automatic done_pulse(input string name);
        door_done = 1'b1;
        tick;
        door_done = 1'b0;
        chk({name, ".close"}, 32'(door_open), 32'd0);
    endtask

    function automatic vec_t mk(input logic [4:0] r, input logic d, input logic [2:0] f,
                                input logic [4:0] p, input logic m, input logic o);
        vec_t v;
        v.req_n = r; v.dd = d; v.fl = f; v.pend = p; v.mov = m; v.door = o;
        return v;
    endfunction

    initial begin
        // Call at floor 0, then a second press of floor 0 while the door runs.
        tbl.push_back(mk(5'b11110, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk(5'b11110, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk(5'b11110, 0, 0, 5'b00001, 0, 0));
        tbl.push_back(mk(5'b11111, 0, 0, 5'b00000, 0, 1));
        tbl.push_back(mk(5'b11111, 0, 0, 5'b00000, 0, 1));
        tbl.push_back(mk(5'b11110, 0, 0, 5'b00000, 0, 1));
        tbl.push_back(mk(5'b11110, 0, 0, 5'b00000, 0, 1));
        tbl.push_back(mk(5'b11110, 0, 0, 5'b00000, 0, 1));
        tbl.push_back(mk(5'b11111, 0, 0, 5'b00000, 0, 1));
        tbl.push_back(mk(5'b11111, 1, 0, 5'b00000, 0, 0));
        tbl.push_back(mk(5'b11111, 0, 0, 5'b00000, 0, 0));
        // Single call to floor 2, button held 10 cycles.
        tbl.push_back(mk(5'b11011, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk(5'b11011, 0, 0, 5'b00000, 0, 0));
        tbl.push_back(mk(5'b11011, 0, 0, 5'b00100, 0, 0));
        tbl.push_back(mk(5'b11011, 0, 0, 5'b00100, 1, 0));
        tbl.push_back(mk(5'b11011, 0, 0, 5'b00100, 1, 0));
        tbl.push_back(mk(5'b11011, 0, 0, 5'b00100, 1, 0));
        tbl.push_back(mk(5'b11011, 0, 0, 5'b00100, 1, 0));
        tbl.push_back(mk(5'b11011, 0, 1, 5'b00100, 1, 0));
        tbl.push_back(mk(5'b11011, 0, 1, 5'b00100, 1, 0));
        tbl.push_back(mk(5'b11011, 0, 1, 5'b00100, 1, 0));
        tbl.push_back(mk(5'b11111, 0, 1, 5'b00100, 1, 0));
        tbl.push_back(mk(5'b11111, 0, 2, 5'b00000, 0, 1));
        tbl.push_back(mk(5'b11111, 0, 2, 5'b00000, 0, 1));
        tbl.push_back(mk(5'b11111, 1, 2, 5'b00000, 0, 0));
        tbl.push_back(mk(5'b11111, 0, 2, 5'b00000, 0, 0));
        // Stray door_done in IDLE has no effect.
        tbl.push_back(mk(5'b11111, 1, 2, 5'b00000, 0, 0));
        tbl.push_back(mk(5'b11111, 0, 2, 5'b00000, 0, 0));

        rst_a_p   = 1'b0;
        req_n     = '1;
        door_done = 1'b0;
        repeat (20) tick;
        chk_out("reset", 0, 5'b00000, 0, 1, 0);
        rst_a_p = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick;
            chk_out($sformatf("idle%0d", c), 0, 5'b00000, 0, 1, 0);
        end

        foreach (tbl[k]) begin
            req_n     = tbl[k].req_n;
            door_done = tbl[k].dd;
            tick;
            chk_out($sformatf("vec%0d", k), tbl[k].fl, tbl[k].pend, tbl[k].mov, 1'b1, tbl[k].door);
        end
        req_n     = '1;
        door_done = 1'b0;

        // SCAN: from floor 2 heading to 4, calls for 1 then 3 arrive.
        req_n = 5'b01111; tick;
        req_n = 5'b01101; tick;
        req_n = 5'b00101; tick;
        repeat (3) tick;
        req_n = '1;
        wait_door("scan3", 3, 1); done_pulse("scan3");
        wait_door("scan4", 4, 1); done_pulse("scan4");
        wait_door("scan1", 1, 0); done_pulse("scan1");
        chk("scan.max_floor", 32'(max_fl), 32'd4);

        // Door stall at floor 2 while calls for 0 and 4 arrive.
        req_n = 5'b11011;
        repeat (4) tick;
        req_n = '1;
        wait_door("stall", 2, 1);
        for (int i = 0; i < 100; i++) begin
            if (i == 10) req_n = 5'b01110;
            if (i == 14) req_n = '1;
            tick;
            chk($sformatf("stall%0d.door_open", i), 32'(door_open), 32'd1);
            chk($sformatf("stall%0d.floor", i),     32'(floor),     32'd2);
        end
        chk("stall.pending", 32'(pending), 32'(5'b10001));
        done_pulse("stall");
        wait_door("after_stall4", 4, 1); done_pulse("after_stall4");
        wait_door("after_stall0", 0, 0); done_pulse("after_stall0");

        // Asynchronous reset while travelling from floor 1 toward 2.
        req_n = 5'b11011;
        repeat (4) tick;
        req_n = '1;
        for (int k = 0; k < 100 && floor !== 3'd1; k++) tick;
        chk("rstmove.reach1", 32'(floor), 32'd1);
        tick;
        chk("rstmove.moving", 32'(moving), 32'd1);
        #2;
        rst_a_p = 1'b0;
        #1;
        chk_out("rst_async", 0, 5'b00000, 0, 1, 0);
        repeat (3) tick;
        rst_a_p = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick;
            chk_out($sformatf("post_rst%0d", c), 0, 5'b00000, 0, 1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
